// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler
// Shares a single SPI shift engine between two requesters with round-robin
// arbitration, generates the SCK timing strobes the engine consumes, routes
// the engine chip select to the device that owns the current transfer, and
// recovers the engine through a watchdog when a transfer never completes.
//
// Ports
//   CLK50MHZ           system clock (single domain)
//   RST                synchronous active-high reset
//   req0/req1          level requests, held until the matching ack
//   wdata0/wdata1      words to shift out, stable while req is high
//   ack0/ack1          one-cycle completion pulses
//   rdata0/rdata1      last word shifted in for each client (held)
//   err                one-cycle pulse on watchdog abort
//   cs0_n/cs1_n        per-device chip selects, active low
//   spi_sck            serial clock to the devices
//   eng_rst            engine reset (RST or abort)
//   eng_trig           engine start pulse
//   eng_data_in        engine parallel load word
//   eng_data_out       engine shift register contents
//   eng_done           engine completion pulse
//   eng_cs             engine chip select, active low
//   eng_sck_trig       SCK edge strobe
//   eng_sck_trig_div2  strobe on every second SCK edge
module spi_bus_scheduler #(
  parameter int WIDTH   = 32,
  parameter int DIV     = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             err,
  output logic             cs0_n,
  output logic             cs1_n,
  output logic             spi_sck,
  output logic             eng_rst,
  output logic             eng_trig,
  output logic [WIDTH-1:0] eng_data_in,
  input  logic [WIDTH-1:0] eng_data_out,
  input  logic             eng_done,
  input  logic             eng_cs,
  output logic             eng_sck_trig,
  output logic             eng_sck_trig_div2
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    BUSY    = 3'd2,
    RELEASE = 3'd3,
    ABORT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             phase_q;
  logic             owner_q, owner_d;
  // Client that wins the next tie. It is loaded with the opposite of the
  // client just served (or aborted), so client 0 goes first after reset and
  // simultaneous requesters alternate.
  logic             prio_q, prio_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] rd0_q, rd0_d;
  logic [WIDTH-1:0] rd1_q, rd1_d;
  logic             sck_strobe;
  logic             win;
  logic             active;

  // Free-running SCK strobe generator
  assign sck_strobe = (cnt_q == CNT_LAST);

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (sck_strobe) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Client 1 wins when it is the only requester or holds the tie priority
  assign win = req1 & (~req0 | prio_q);

  // Arbitration / transfer FSM: state register
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      wd_q    <= '0;
      din_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      wd_q    <= wd_d;
      din_q   <= din_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  // Arbitration / transfer FSM: next state
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    wd_d    = wd_q;
    din_d   = din_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = win;
          din_d   = win ? wdata1 : wdata0;
          wd_d    = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = BUSY;
      end
      BUSY: begin
        wd_d = wd_q + WW'(1);
        if (eng_done) begin
          if (owner_q) rd1_d = eng_data_out;
          else         rd0_d = eng_data_out;
          state_d = RELEASE;
        end else if (wd_q == WD_LAST) begin
          state_d = ABORT;
        end
      end
      RELEASE: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      ABORT: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state
  assign active = (state_q == LOAD) || (state_q == BUSY);

  assign ack0              = (state_q == RELEASE) & ~owner_q;
  assign ack1              = (state_q == RELEASE) &  owner_q;
  assign err               = (state_q == ABORT);
  assign eng_trig          = (state_q == LOAD);
  assign eng_rst           = RST | err;
  assign eng_data_in       = din_q;
  assign rdata0            = rd0_q;
  assign rdata1            = rd1_q;
  assign cs0_n             = (active & ~owner_q) ? eng_cs : 1'b1;
  assign cs1_n             = (active &  owner_q) ? eng_cs : 1'b1;
  assign spi_sck           = (state_q == BUSY) & ~eng_cs & phase_q;
  assign eng_sck_trig      = sck_strobe;
  assign eng_sck_trig_div2 = sck_strobe & phase_q;

endmodule

// File: tb/tb_spi_bus_scheduler.sv
`timescale 1ns/1ps
module tb_spi_bus_scheduler;
  localparam int WIDTH   = 32;
  localparam int DIV     = 4;
  localparam int TIMEOUT = 200;

  logic             CLK50MHZ, RST, req0, req1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             ack0, ack1, err, cs0_n, cs1_n, spi_sck, eng_rst, eng_trig;
  logic             eng_sck_trig, eng_sck_trig_div2;
  logic [WIDTH-1:0] rdata0, rdata1, eng_data_in;
  logic [WIDTH-1:0] eng_data_out;
  logic             eng_done, eng_cs;

  spi_bus_scheduler #(.WIDTH(WIDTH), .DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .req0(req0), .req1(req1),
    .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1), .err(err), .cs0_n(cs0_n), .cs1_n(cs1_n),
    .spi_sck(spi_sck), .eng_rst(eng_rst), .eng_trig(eng_trig),
    .eng_data_in(eng_data_in), .eng_data_out(eng_data_out),
    .eng_done(eng_done), .eng_cs(eng_cs), .eng_sck_trig(eng_sck_trig),
    .eng_sck_trig_div2(eng_sck_trig_div2)
  );

  initial begin
    CLK50MHZ = 1'b0;
    forever #10 CLK50MHZ = ~CLK50MHZ;
  end

  // Engine stub: loads on eng_trig, holds eng_cs low for stub_len+1 cycles,
  // then returns the loaded word XOR stub_mask with a done pulse.
  int unsigned      stub_len;
  logic [WIDTH-1:0] stub_mask;
  logic             stub_hang, stray;
  logic             stub_busy;
  int unsigned      stub_cnt;
  logic [WIDTH-1:0] stub_sr;

  always @(posedge CLK50MHZ) begin
    if (eng_rst) begin
      stub_busy    <= 1'b0;
      stub_cnt     <= 0;
      stub_sr      <= '0;
      eng_cs       <= 1'b1;
      eng_done     <= 1'b0;
      eng_data_out <= '0;
    end else begin
      eng_done <= 1'b0;
      if (stray) begin
        eng_done     <= 1'b1;
        eng_data_out <= 32'hDEAD_BEEF;
      end else if (eng_trig) begin
        stub_busy <= 1'b1;
        eng_cs    <= 1'b0;
        stub_cnt  <= stub_len;
        stub_sr   <= eng_data_in ^ stub_mask;
      end else if (stub_busy && !stub_hang) begin
        if (stub_cnt == 0) begin
          eng_done     <= 1'b1;
          stub_busy    <= 1'b0;
          eng_cs       <= 1'b1;
          eng_data_out <= stub_sr;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  // Inputs as seen by the DUT on the last active edge
  logic             rq0_s, rq1_s, rst_s;
  logic [WIDTH-1:0] wd0_s, wd1_s;
  always @(posedge CLK50MHZ) begin
    rq0_s <= req0;
    rq1_s <= req1;
    wd0_s <= wdata0;
    wd1_s <= wdata1;
    rst_s <= RST;
  end

  int vectors, miscompares, cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level reference model
  logic             mon_en, busy_m, owner_m, next_pri_m, ack_prev;
  logic [WIDTH-1:0] exp_word, mask_m, exp_rd0, exp_rd1;
  int               grant_log[$];
  int               ack_cnt0, ack_cnt1, err_cnt;

  task automatic mon_cycle();
    logic [1:0] exp_cs;
    if (rst_s === 1'b1) begin
      busy_m = 1'b0; next_pri_m = 1'b0; ack_prev = 1'b0;
      exp_rd0 = '0; exp_rd1 = '0;
      return;
    end
    if (!mon_en) return;
    if (eng_trig) begin
      chk("trig_while_busy", busy_m, 0);
      chk("grant_has_req", rq0_s | rq1_s, 1);
      owner_m  = (rq0_s & rq1_s) ? next_pri_m : rq1_s;
      exp_word = owner_m ? wd1_s : wd0_s;
      chk("eng_data_in", eng_data_in, exp_word);
      mask_m = stub_mask;
      busy_m = 1'b1;
      grant_log.push_back(int'(owner_m));
    end
    if (ack0 | ack1) begin
      chk("ack_owner", {ack1, ack0}, busy_m ? (owner_m ? 2'b10 : 2'b01) : 2'b00);
      chk("ack_len", ack_prev, 0);
      if (owner_m) exp_rd1 = exp_word ^ mask_m;
      else         exp_rd0 = exp_word ^ mask_m;
      chk("rdata0", rdata0, exp_rd0);
      chk("rdata1", rdata1, exp_rd1);
      if (ack0) ack_cnt0++;
      if (ack1) ack_cnt1++;
      next_pri_m = ~owner_m;
      busy_m = 1'b0;
    end
    ack_prev = ack0 | ack1;
    if (err) begin
      chk("err_expected", busy_m & stub_hang, 1);
      chk("eng_rst_abort", eng_rst, 1);
      chk("rdata0_abort", rdata0, exp_rd0);
      chk("rdata1_abort", rdata1, exp_rd1);
      next_pri_m = ~owner_m;
      busy_m = 1'b0;
      err_cnt++;
    end
    exp_cs = busy_m ? (owner_m ? {eng_cs, 1'b1} : {1'b1, eng_cs}) : 2'b11;
    chk("cs_route", {cs1_n, cs0_n}, exp_cs);
    if (cs0_n & cs1_n) chk("sck_idle", spi_sck, 0);
  endtask

  task automatic step();
    @(negedge CLK50MHZ);
    cyc++;
    mon_cycle();
  endtask

  function automatic logic sig_now(input int w);
    case (w)
      0:       return eng_trig;
      1:       return ack0;
      2:       return ack1;
      default: return err;
    endcase
  endfunction

  task automatic wait_sig(input int w, input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      seen = sig_now(w);
    end
    chk(name, seen, 1);
  endtask

  typedef struct {
    logic r0, r1;
    logic trig, div2, sck, cs0n, cs1n;
  } vec_t;
  vec_t tbl[64];

  initial begin
    logic [WIDTH-1:0] save0, word;
    int t_busy, extra, a0, a1, e0, k0, n, cnt0, cnt1;
    logic got0, got1, re0, re1;

    for (int i = 0; i < 64; i++) begin
      tbl[i].r0 = 1'b0; tbl[i].r1 = 1'b0;
      tbl[i].trig = ((i + 1) % DIV == DIV - 1);
      tbl[i].div2 = ((i + 1) % (2 * DIV) == 2 * DIV - 1);
      tbl[i].sck = 1'b0; tbl[i].cs0n = 1'b1; tbl[i].cs1n = 1'b1;
    end

    vectors = 0; miscompares = 0; cyc = 0;
    mon_en = 1'b0; busy_m = 1'b0; owner_m = 1'b0; next_pri_m = 1'b0; ack_prev = 1'b0;
    exp_word = '0; mask_m = '0; exp_rd0 = '0; exp_rd1 = '0;
    ack_cnt0 = 0; ack_cnt1 = 0; err_cnt = 0;
    RST = 1'b1; req0 = 1'b0; req1 = 1'b0; wdata0 = '0; wdata1 = '0;
    stub_len = 10; stub_mask = '0; stub_hang = 1'b0; stray = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_err", err, 0);
    chk("rst_trig", eng_trig, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_din", eng_data_in, 0);
    chk("rst_cs", {cs1_n, cs0_n}, 2'b11);
    chk("rst_sck", spi_sck, 0);
    chk("rst_strobe", {eng_sck_trig_div2, eng_sck_trig}, 0);
    RST = 1'b0;
    mon_en = 1'b1;

    // Idle strobe pattern
    for (int i = 0; i < 64; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1;
      step();
      chk("sck_trig", eng_sck_trig, tbl[i].trig);
      chk("sck_trig_div2", eng_sck_trig_div2, tbl[i].div2);
      chk("idle_sck", spi_sck, tbl[i].sck);
      chk("idle_cs0", cs0_n, tbl[i].cs0n);
      chk("idle_cs1", cs1_n, tbl[i].cs1n);
      chk("idle_eng_rst", eng_rst, 0);
    end

    // Loopback transfer for client 0
    a0 = ack_cnt0;
    req0 = 1'b1; wdata0 = 32'hA5A5_0F0F; stub_mask = '0; stub_len = 10;
    step();
    chk("trig_latency", eng_trig, 1);
    extra = 0; got0 = 1'b0;
    for (int k = 0; k < 100 && !got0; k++) begin
      step();
      if (eng_trig) extra++;
      chk("lb_cs1_high", cs1_n, 1);
      got0 = ack0;
    end
    chk("lb_ack0_seen", got0, 1);
    req0 = 1'b0;
    chk("lb_extra_trig", extra, 0);
    chk("lb_rdata0", rdata0, 32'hA5A5_0F0F);
    step();
    chk("lb_ack0_one_cycle", ack0, 0);
    chk("lb_ack0_count", ack_cnt0 - a0, 1);

    // Stray eng_done while idle is ignored
    stray = 1'b1;
    step();
    stray = 1'b0;
    repeat (3) step();
    chk("stray_rdata0", rdata0, 32'hA5A5_0F0F);
    chk("stray_rdata1", rdata1, 0);
    chk("stray_acks", ack_cnt0 + ack_cnt1, a0 + 1);

    // req1 dropped one cycle after grant: transfer still completes
    a1 = ack_cnt1;
    word = $urandom;
    req1 = 1'b1; wdata1 = word; stub_mask = $urandom; stub_len = 20;
    wait_sig(0, 5, "drop_trig_seen");
    step();
    req1 = 1'b0;
    wait_sig(2, 100, "drop_ack1_seen");
    chk("drop_rdata1", rdata1, word ^ stub_mask);
    repeat (3) step();
    chk("drop_ack1_count", ack_cnt1 - a1, 1);

    // Watchdog abort of client 0, then client 1 takes the next turn
    save0 = rdata0; e0 = err_cnt; a0 = ack_cnt0;
    stub_hang = 1'b1;
    req0 = 1'b1; wdata0 = $urandom;
    wait_sig(0, 5, "wd_trig_seen");
    t_busy = cyc + 1;
    wait_sig(3, 300, "wd_err_seen");
    chk("wd_err_latency", cyc - t_busy, TIMEOUT);
    chk("wd_no_ack", ack0, 0);
    chk("wd_eng_rst", eng_rst, 1);
    chk("wd_rdata0_kept", rdata0, save0);
    k0 = grant_log.size();
    stub_hang = 1'b0;
    req1 = 1'b1; wdata1 = $urandom;
    got0 = 1'b0; got1 = 1'b0;
    for (int k = 0; k < 300 && !(got0 && got1); k++) begin
      step();
      if (ack0) begin req0 = 1'b0; got0 = 1'b1; end
      if (ack1) begin req1 = 1'b0; got1 = 1'b1; end
    end
    chk("wd_both_served", {got1, got0}, 2'b11);
    chk("wd_err_count", err_cnt - e0, 1);
    chk("wd_next_grant", grant_log.size() > k0 ? grant_log[k0] : -1, 1);
    chk("wd_then_grant", grant_log.size() > k0 + 1 ? grant_log[k0 + 1] : -1, 0);

    // Reset in the middle of a client-1 transfer
    stub_len = 60;
    a1 = ack_cnt1;
    req1 = 1'b1; wdata1 = $urandom;
    wait_sig(0, 5, "mid_trig_seen");
    repeat (5) step();
    chk("mid_cs1_low", cs1_n, 0);
    RST = 1'b1; req1 = 1'b0;
    step();
    chk("mid_cs1_high", cs1_n, 1);
    chk("mid_cs0_high", cs0_n, 1);
    chk("mid_ack1", ack1, 0);
    chk("mid_rdata1", rdata1, 0);
    chk("mid_eng_rst", eng_rst, 1);
    RST = 1'b0;
    e0 = err_cnt;
    repeat (80) step();
    chk("mid_no_ack1", ack_cnt1 - a1, 0);
    chk("mid_no_err", err_cnt - e0, 0);

    // Both clients held: grants alternate starting from client 0
    stub_len = 8;
    k0 = grant_log.size();
    req0 = 1'b1; req1 = 1'b1; wdata0 = $urandom; wdata1 = $urandom;
    cnt0 = 0; cnt1 = 0; n = 0; re0 = 1'b0; re1 = 1'b0;
    while ((cnt0 + cnt1) < 4 && n < 400) begin
      step(); n++;
      if (re0) begin req0 = 1'b1; wdata0 = $urandom; re0 = 1'b0; end
      if (re1) begin req1 = 1'b1; wdata1 = $urandom; re1 = 1'b0; end
      if (ack0) begin req0 = 1'b0; cnt0++; re0 = (cnt0 < 2); end
      if (ack1) begin req1 = 1'b0; cnt1++; re1 = (cnt1 < 2); end
    end
    chk("rr_acks", cnt0 + cnt1, 4);
    repeat (4) step();
    chk("rr_grants", grant_log.size() - k0, 4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", grant_log.size() > k0 + i ? grant_log[k0 + i] : -1, i % 2);

    // Randomized traffic checked by the reference model
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!busy_m) begin
        stub_len  = $urandom_range(0, 40);
        stub_mask = $urandom;
      end
      if (ack0) req0 = 1'b0;
      else if (!(busy_m && owner_m == 1'b0)) begin
        if (!req0 && $urandom_range(0, 3) == 0) begin req0 = 1'b1; wdata0 = $urandom; end
        else if (req0 && $urandom_range(0, 31) == 0) req0 = 1'b0;
      end
      if (ack1) req1 = 1'b0;
      else if (!(busy_m && owner_m == 1'b1)) begin
        if (!req1 && $urandom_range(0, 3) == 0) begin req1 = 1'b1; wdata1 = $urandom; end
        else if (req1 && $urandom_range(0, 31) == 0) req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 300 && busy_m; k++) begin
      step();
    end
    chk("drain_idle", busy_m, 0);
    chk("rand_no_err", err_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
